instr_prefetch: RTL
===================

INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the instruction word width on mem_rdata and fifo_din.
REQ-002 Parameter ADDR_WIDTH, default 16, SHALL set the fetch address width.
REQ-003 Parameter RESET_PC, default 0, SHALL set the fetch address loaded at reset.
REQ-004 clk  input  1  SHALL be the clock; all state changes occur on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 enable  input  1  SHALL permit new fetches when high.
REQ-007 redirect  input  1  SHALL request a fetch-address change (branch/jump).
REQ-008 redirect_pc  input  ADDR_WIDTH  SHALL carry the new fetch address, sampled when redirect=1.
REQ-009 mem_req  output  1  SHALL be the memory read request.
REQ-010 mem_addr  output  ADDR_WIDTH  SHALL be the memory read address.
REQ-011 mem_ack  input  1  SHALL indicate that mem_rdata is valid for the current request.
REQ-012 mem_rdata  input  DATA_WIDTH  SHALL carry the read data.
REQ-013 fifo_full  input  1  SHALL be the full flag from the downstream instruction FIFO.
REQ-014 fifo_wr  output  1  SHALL be a one-cycle write strobe to the FIFO.
REQ-015 fifo_din  output  DATA_WIDTH  SHALL carry the word being written.
REQ-016 fetch_pc  output  ADDR_WIDTH  SHALL present the address of the next word to be pushed.
REQ-017 busy  output  1  SHALL be high whenever state != IDLE.

Function
REQ-018 The block SHALL implement an FSM with states IDLE, REQ and PUSH, plus registers pc, hold_data and discard.
REQ-019 IDLE: if redirect=1, the block SHALL set pc <= redirect_pc; else if enable=1 and fifo_full=0, it SHALL go to REQ on the next edge.
REQ-020 REQ: the block SHALL drive mem_req=1 and mem_addr=pc combinationally.
REQ-021 mem_req and mem_addr SHALL stay stable until the cycle in which mem_ack=1; mem_req SHALL never drop before mem_ack.
REQ-022 REQ with mem_ack=1 and discard=0: the block SHALL capture hold_data <= mem_rdata and go to PUSH.
REQ-023 PUSH with fifo_full=0: the block SHALL drive fifo_wr=1 and fifo_din=hold_data, and set pc <= pc+1.
REQ-024 After a push, the next state SHALL be REQ if enable=1, else IDLE.
REQ-025 PUSH with fifo_full=1: the block SHALL hold with fifo_wr=0 and keep hold_data and pc unchanged.
REQ-026 fifo_wr SHALL be asserted only in PUSH with fifo_full=0; the block SHALL never write to a full FIFO.
REQ-027 Best-case throughput SHALL be one word per 2 cycles (REQ with immediate ack, then PUSH); mem_ack-to-fifo_wr latency SHALL be 1 cycle.
REQ-028 pc+1 SHALL wrap from 2^ADDR_WIDTH-1 to 0.
REQ-029 redirect SHALL have highest priority in every state and SHALL set pc <= redirect_pc.
REQ-030 Redirect in REQ without mem_ack: the block SHALL set discard=1 and keep mem_req and mem_addr unchanged until mem_ack.
REQ-031 Redirect in REQ with mem_ack in the same cycle: the data SHALL be dropped and the next state SHALL be REQ with mem_addr=redirect_pc.
REQ-032 REQ with mem_ack=1 and discard=1: the data SHALL be dropped, discard SHALL clear, and the next state SHALL be REQ (the new address).
REQ-033 Redirect in PUSH: the block SHALL drive fifo_wr=0 that cycle, discard hold_data, and go to REQ.
REQ-034 enable=0 SHALL not abort an outstanding request or a held word; the block SHALL reach IDLE only after the current word is pushed or discarded.
REQ-035 fetch_pc SHALL equal pc.

Reset
REQ-036 On rst=0, the block SHALL immediately set state=IDLE, pc=RESET_PC, discard=0, hold_data=0 and busy=0.
REQ-037 During reset, mem_req, fifo_wr and fifo_din SHALL all be 0.
REQ-038 Reset asserted mid-transaction SHALL abandon the transaction; the memory side SHALL tolerate the dropped mem_req.
REQ-039 After rst rises, the first mem_req SHALL occur no earlier than the second rising edge with enable=1.

Verification
REQ-040 Streaming: reset, enable=1, memory acks each request on the same cycle with rdata=addr[7:0] -> fifo_din 0x00,0x01,0x02... on every 2nd cycle; fetch_pc increments after each push.
REQ-041 Backpressure: hold fifo_full=1 for 5 cycles while in PUSH -> fifo_wr=0 and hold_data stable; on release, exactly one fifo_wr with the held value.
REQ-042 Redirect during wait: mem_ack delayed 3 cycles, redirect_pc=0x0100 pulsed in cycle 1 -> mem_addr unchanged until ack, acked data not written, next mem_addr=0x0100.
REQ-043 Redirect with ack or in PUSH: redirect coincident with mem_ack, and separately in PUSH -> no fifo_wr; next request at the redirect address.
REQ-044 Wrap: RESET_PC=0xFFFF -> after push of word 0xFFFF, fetch_pc=0x0000 and mem_addr=0x0000.
REQ-045 Async reset: rst=0 mid-REQ between edges -> mem_req=0, busy=0 and fetch_pc=RESET_PC immediately.

Source files
------------

// File: rtl/instr_prefetch_if.sv
// Memory-read and instruction-FIFO-write signals of the instruction prefetcher.
// master = prefetcher side, slave = memory/FIFO side.
interface instr_prefetch_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  fifo_full;
  logic                  fifo_wr;
  logic [DATA_WIDTH-1:0] fifo_din;

  modport master (
    output mem_req, mem_addr, fifo_wr, fifo_din,
    input  mem_ack, mem_rdata, fifo_full
  );

  modport slave (
    input  mem_req, mem_addr, fifo_wr, fifo_din,
    output mem_ack, mem_rdata, fifo_full
  );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: fetches sequential words from memory into an instruction
// FIFO, one outstanding request at a time, with redirect (branch/jump) support.
module instr_prefetch #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  instr_prefetch_if.master      bus,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [ADDR_WIDTH-1:0] req_addr, req_addr_nxt;
  logic [DATA_WIDTH-1:0] hold_data, hold_nxt;
  logic                  discard, discard_nxt;
  logic [ADDR_WIDTH-1:0] pc_inc;

  logic                  mem_req_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic                  fifo_wr_c;
  logic [DATA_WIDTH-1:0] fifo_din_c;

  assign pc_inc = pc + ADDR_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      hold_data <= '0;
      discard   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      req_addr  <= req_addr_nxt;
      hold_data <= hold_nxt;
      discard   <= discard_nxt;
    end
  end

  // A redirect while a request is outstanding moves pc immediately, so the
  // in-flight address is parked in req_addr to keep mem_addr stable until ack.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    hold_nxt     = hold_data;
    discard_nxt  = discard;
    mem_req_c    = 1'b0;
    mem_addr_c   = pc;
    fifo_wr_c    = 1'b0;
    fifo_din_c   = '0;

    case (state)
      IDLE: begin
        if (redirect) begin
          pc_nxt = redirect_pc;
        end else if (enable && !bus.fifo_full) begin
          state_nxt = REQ;
        end
      end

      REQ: begin
        mem_req_c  = 1'b1;
        mem_addr_c = discard ? req_addr : pc;
        if (bus.mem_ack) begin
          if (redirect) begin
            pc_nxt      = redirect_pc;
            discard_nxt = 1'b0;
          end else if (discard) begin
            discard_nxt = 1'b0;
          end else begin
            hold_nxt  = bus.mem_rdata;
            state_nxt = PUSH;
          end
        end else if (redirect) begin
          pc_nxt = redirect_pc;
          if (!discard) begin
            discard_nxt  = 1'b1;
            req_addr_nxt = pc;
          end
        end
      end

      PUSH: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          hold_nxt  = '0;
          state_nxt = REQ;
        end else if (!bus.fifo_full) begin
          fifo_wr_c  = 1'b1;
          fifo_din_c = hold_data;
          pc_nxt     = pc_inc;
          state_nxt  = enable ? REQ : IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mem_req  = mem_req_c;
  assign bus.mem_addr = mem_addr_c;
  assign bus.fifo_wr  = fifo_wr_c;
  assign bus.fifo_din = fifo_din_c;
  assign fetch_pc     = pc;
  assign busy         = (state != IDLE);

endmodule
